// File: rtl/lcd_16207_pkg.sv
// rtl/lcd_16207_pkg.sv - shared types, init commands and helpers for the 16207 LCD sequencer
// No ports: holds the sequencer state enum, the power-up command bytes,
// the long-command classifier and a zero-to-one cycle clamp.
package lcd_16207_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        EXEC_WAIT
    } state_t;

    localparam logic [7:0] INIT_FUNC  = 8'h38;
    localparam logic [7:0] INIT_DISP  = 8'h0C;
    localparam logic [7:0] INIT_CLR   = 8'h01;
    localparam logic [7:0] INIT_ENTRY = 8'h06;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_FUNC;
            2'd1:    return INIT_DISP;
            2'd2:    return INIT_CLR;
            default: return INIT_ENTRY;
        endcase
    endfunction

    // A zero-cycle timing parameter still occupies one cycle.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/lcd_16207_delay_cnt.sv
// rtl/lcd_16207_delay_cnt.sv - loadable down-counter used to time every sequencer state
// Ports: clk, reset (async, active-high, loads RESET_VALUE), load/load_value
// (synchronous reload), zero (count has reached 0; counting stops there).
module lcd_16207_delay_cnt #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_16207_sequencer.sv
// rtl/lcd_16207_sequencer.sv - power-up init and E-pulse timing for a 16207 character LCD
// Ports: clk, reset (async, active-high); request side req_valid/req_ready with
// req_rs/req_rw/req_data; response side rsp_valid (pulse) and rsp_data (held);
// init_done; LCD pins LCD_E/LCD_RS/LCD_RW and split tristate
// LCD_data_out/LCD_data_oe/LCD_data_in.
module lcd_16207_sequencer
    import lcd_16207_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 3,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 82000,
    parameter int unsigned POWERUP_CYC    = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_rw,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [7:0] LCD_data_in
);

    localparam int unsigned S_N  = at_least_one(SETUP_CYC);
    localparam int unsigned E_N  = at_least_one(E_HIGH_CYC);
    localparam int unsigned H_N  = at_least_one(HOLD_CYC);
    localparam int unsigned CM_N = at_least_one(CMD_WAIT_CYC);
    localparam int unsigned CL_N = at_least_one(CLEAR_WAIT_CYC);
    localparam int unsigned PU_N = at_least_one(POWERUP_CYC);

    localparam int unsigned MAX_A   = (S_N > E_N) ? S_N : E_N;
    localparam int unsigned MAX_B   = (H_N > CM_N) ? H_N : CM_N;
    localparam int unsigned MAX_C   = (CL_N > PU_N) ? CL_N : PU_N;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    // Counters load N-1 on state entry so each timed state lasts exactly N cycles.
    localparam logic [CW-1:0] SETUP_LD = CW'(S_N - 1);
    localparam logic [CW-1:0] EHIGH_LD = CW'(E_N - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(H_N - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CM_N - 1);
    localparam logic [CW-1:0] CLEAR_LD = CW'(CL_N - 1);
    localparam logic [CW-1:0] POWER_LD = CW'(PU_N - 1);

    state_t        state, next_state;
    logic          cnt_load, cnt_zero;
    logic [CW-1:0] cnt_value;
    logic          rs_q, rw_q;
    logic [7:0]    data_q;
    logic [1:0]    init_idx;
    logic          accept, init_ld, capture, rsp_set, idx_inc, init_fin;

    lcd_16207_delay_cnt #(
        .WIDTH       (CW),
        .RESET_VALUE (POWER_LD)
    ) u_delay_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PWR_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        accept     = 1'b0;
        init_ld    = 1'b0;
        capture    = 1'b0;
        rsp_set    = 1'b0;
        idx_inc    = 1'b0;
        init_fin   = 1'b0;
        case (state)
            PWR_WAIT: begin
                if (cnt_zero) next_state = INIT_LOAD;
            end
            INIT_LOAD: begin
                init_ld    = 1'b1;
                next_state = SETUP;
                cnt_load   = 1'b1;
                cnt_value  = SETUP_LD;
            end
            IDLE: begin
                // req_ready depends only on registered state, never on req_valid.
                if (init_done && req_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                    cnt_load   = 1'b1;
                    cnt_value  = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    next_state = E_HIGH;
                    cnt_load   = 1'b1;
                    cnt_value  = EHIGH_LD;
                end
            end
            E_HIGH: begin
                if (cnt_zero) begin
                    capture    = rw_q;
                    next_state = HOLD;
                    cnt_load   = 1'b1;
                    cnt_value  = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    if (rw_q) begin
                        rsp_set    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = EXEC_WAIT;
                        cnt_load   = 1'b1;
                        cnt_value  = is_long_cmd(rs_q, data_q) ? CLEAR_LD : CMD_LD;
                    end
                end
            end
            EXEC_WAIT: begin
                if (cnt_zero) begin
                    if (init_done) begin
                        next_state = IDLE;
                    end else if (init_idx == 2'd3) begin
                        init_fin   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        idx_inc    = 1'b1;
                        next_state = INIT_LOAD;
                    end
                end
            end
            default: next_state = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            data_q    <= 8'h00;
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            rsp_valid <= rsp_set;
            if (accept) begin
                rs_q   <= req_rs;
                rw_q   <= req_rw;
                data_q <= req_data;
            end else if (init_ld) begin
                rs_q   <= 1'b0;
                rw_q   <= 1'b0;
                data_q <= init_cmd(init_idx);
            end
            if (capture) rsp_data <= LCD_data_in;
            if (idx_inc) init_idx <= init_idx + 2'd1;
            if (init_fin) begin
                init_done <= 1'b1;
                init_idx  <= 2'd0;
            end
        end
    end

    // E and the pad enable decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock edge.
    assign LCD_E        = (state == E_HIGH);
    assign LCD_data_oe  = !rw_q && ((state == SETUP) || (state == E_HIGH) || (state == HOLD));
    assign LCD_RS       = rs_q;
    assign LCD_RW       = rw_q;
    assign LCD_data_out = data_q;
    assign req_ready    = (state == IDLE) && init_done;

endmodule

// File: tb/tb_lcd_16207_sequencer.sv
// tb/tb_lcd_16207_sequencer.sv - scoreboard bench for the 16207 LCD sequencer
module tb_lcd_16207_sequencer;

    localparam int S_C  = 2;
    localparam int EH_C = 3;
    localparam int H_C  = 1;
    localparam int CM_C = 5;
    localparam int CL_C = 20;
    localparam int PU_C = 10;

    localparam int WR_LAT    = 1 + S_C + EH_C + H_C + CM_C;
    localparam int WR_LONG   = 1 + S_C + EH_C + H_C + CL_C;
    localparam int RD_LAT    = 1 + S_C + EH_C + H_C;
    localparam int INIT_SHORT_GAP = H_C + CM_C + 1 + S_C;
    localparam int INIT_LONG_GAP  = H_C + CL_C + 1 + S_C;
    localparam int INIT_FIRST_GAP = PU_C + 1 + S_C;
    localparam int INIT_LAT  = INIT_FIRST_GAP + 4 * EH_C + 2 * INIT_SHORT_GAP
                             + INIT_LONG_GAP + H_C + CM_C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_rw = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, rsp_valid, init_done;
    logic [7:0] rsp_data;
    logic       LCD_E, LCD_RS, LCD_RW, LCD_data_oe;
    logic [7:0] LCD_data_out, LCD_data_in;
    logic [7:0] rd_value = 8'h80;

    assign LCD_data_in = LCD_E ? rd_value : 8'h5A;

    lcd_16207_sequencer #(
        .SETUP_CYC      (S_C),
        .E_HIGH_CYC     (EH_C),
        .HOLD_CYC       (H_C),
        .CMD_WAIT_CYC   (CM_C),
        .CLEAR_WAIT_CYC (CL_C),
        .POWERUP_CYC    (PU_C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs       (req_rs),
        .req_rw       (req_rw),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .LCD_E        (LCD_E),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW),
        .LCD_data_out (LCD_data_out),
        .LCD_data_oe  (LCD_data_oe),
        .LCD_data_in  (LCD_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] data;
        int         gap;
    } pulse_t;

    pulse_t     exp_pulses[$];
    logic [7:0] exp_rsp[$];
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: reconstructs each E pulse from the pins and checks it against the queue.
    logic        e_prev = 1'b0;
    int          gap = 0, rise_gap = 0, width = 0, oe_run = 0;
    logic [10:0] h1 = '0, h2 = '0, pv = '0;
    logic        stable = 1'b0;

    always @(negedge clk) begin : monitor
        logic [10:0] cur;
        pulse_t      e;
        cur = {LCD_RS, LCD_RW, LCD_data_out, LCD_data_oe};
        if (reset) begin
            gap    = 0;
            width  = 0;
            oe_run = 0;
            h1     = '0;
            h2     = '0;
        end else begin
            if (LCD_E && !e_prev) begin
                width    = 1;
                pv       = cur;
                rise_gap = gap;
                stable   = (h1 == cur) && (h2 == cur);
            end else if (LCD_E) begin
                width++;
                if (cur != pv) stable = 1'b0;
            end else if (e_prev) begin
                chk("pulse_expected", 32'(exp_pulses.size() != 0), 32'd1);
                if (exp_pulses.size() != 0) begin
                    e = exp_pulses.pop_front();
                    chk("pulse_rs_rw", 32'({pv[10], pv[9]}), 32'({e.rs, e.rw}));
                    if (!e.rw) chk("pulse_data", 32'(pv[8:1]), 32'(e.data));
                    chk("pulse_oe", 32'(pv[0]), 32'(!e.rw));
                    chk("pulse_width", 32'(width), 32'(EH_C));
                    chk("setup_hold_stable", 32'(stable && (cur == pv)), 32'd1);
                    if (e.gap >= 0) chk("pulse_gap", 32'(rise_gap), 32'(e.gap));
                end
                gap = 1;
            end else begin
                gap++;
            end
            if (LCD_data_oe) begin
                oe_run++;
            end else if (oe_run != 0) begin
                chk("oe_window", 32'(oe_run), 32'(S_C + EH_C + H_C));
                oe_run = 0;
            end
            if (rsp_valid) begin
                chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
                if (exp_rsp.size() != 0) chk("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
            end
        end
        e_prev = LCD_E;
        h2     = h1;
        h1     = cur;
    end

    task automatic push_init();
        exp_pulses.push_back('{1'b0, 1'b0, 8'h38, INIT_FIRST_GAP});
        exp_pulses.push_back('{1'b0, 1'b0, 8'h0C, INIT_SHORT_GAP});
        exp_pulses.push_back('{1'b0, 1'b0, 8'h01, INIT_SHORT_GAP});
        exp_pulses.push_back('{1'b0, 1'b0, 8'h06, INIT_LONG_GAP});
    endtask

    task automatic wait_init();
        int   n;
        logic ok;
        @(posedge clk);
        #1 reset = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        chk("init_wait", 32'(ok), 32'd1);
        chk("init_latency", 32'(n), 32'(INIT_LAT));
        chk("ready_after_init", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rs, input logic rw, input logic [7:0] d, input logic keep);
        logic ok;
        exp_pulses.push_back('{rs, rw, d, -1});
        if (rw) exp_rsp.push_back(rd_value);
        req_rs    = rs;
        req_rw    = rw;
        req_data  = d;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_wait", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_ready(input int want, input logic is_read);
        int n;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
        end
        chk("ready_latency", 32'(n), 32'(want));
        if (is_read) chk("rsp_with_ready", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        push_init();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({LCD_E, LCD_RS, LCD_RW, LCD_data_out, LCD_data_oe,
                 req_ready, rsp_valid, rsp_data, init_done}), 32'd0);
        wait_init();

        send(1'b1, 1'b0, 8'h41, 1'b0);  wait_ready(WR_LAT, 1'b0);
        rd_value = 8'h80;
        send(1'b0, 1'b1, 8'h00, 1'b0);  wait_ready(RD_LAT, 1'b1);
        rd_value = 8'h3C;
        send(1'b1, 1'b1, 8'h00, 1'b0);  wait_ready(RD_LAT, 1'b1);
        send(1'b0, 1'b0, 8'h02, 1'b0);  wait_ready(WR_LONG, 1'b0);
        send(1'b0, 1'b0, 8'h03, 1'b0);  wait_ready(WR_LONG, 1'b0);
        send(1'b0, 1'b0, 8'h04, 1'b0);  wait_ready(WR_LAT, 1'b0);
        send(1'b0, 1'b0, 8'h00, 1'b0);  wait_ready(WR_LAT, 1'b0);
        send(1'b1, 1'b0, 8'h01, 1'b0);  wait_ready(WR_LAT, 1'b0);

        send(1'b1, 1'b0, 8'h42, 1'b1);
        send(1'b1, 1'b0, 8'h43, 1'b0);
        wait_ready(WR_LAT, 1'b0);

        send(1'b1, 1'b0, 8'h55, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (LCD_E) break;
            @(posedge clk);
            #1;
        end
        chk("e_reached", 32'(LCD_E), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_e_async", 32'(LCD_E), 32'd0);
        chk("reset_oe_async", 32'(LCD_data_oe), 32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);
        exp_pulses.delete();
        exp_rsp.delete();
        push_init();
        repeat (2) @(posedge clk);
        wait_init();

        send(1'b1, 1'b0, 8'h5A, 1'b0);  wait_ready(WR_LAT, 1'b0);
        repeat (5) @(negedge clk);
        chk("pulses_drained", 32'(exp_pulses.size()), 32'd0);
        chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted at %0t", $time);
        $fatal(1);
    end

endmodule
